// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } dmem_state_e;

   localparam int WORD_BYTES = 4;
   localparam int LANE_BITS  = 8;

   // Misaligned, below the window base, or past the last word of the array.
   function automatic logic addr_err(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] depth);
      logic [31:0] off;
      off = addr - base;
      return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
   endfunction

endpackage

// File: rtl/dmem_array_32.sv
// Single-port synchronous data RAM, DEPTH_WORDS x 32, byte write enables, registered read.
module dmem_array_32
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic                           clk,
   input  logic                           en,
   input  logic [3:0]                     we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Read port only updates on a pure read so the last load result holds.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we != 4'b0000) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
               if (we[i]) mem[addr][i*LANE_BITS +: LANE_BITS] <= wdata[i*LANE_BITS +: LANE_BITS];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_responder_32.sv
// Load/store responder with programmable wait states in front of the data RAM.
// Optional byte-lane stores when DMEM_BYTE_LANES_EN is defined.
//
// state  | meaning
// IDLE   | req_ready high, capture request on handshake
// WAIT   | wait-state down-counter running, exits at terminal count 0
// ACCESS | error check, RAM write or read issue (one cycle)
// RESP   | rsp_valid high, hold result until rsp_ready
module dmem_responder_32
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_LANES_EN
   input  logic [3:0]  req_be,
`endif
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   dmem_state_e state_q, state_d;
   logic [3:0]  cnt_q;
   logic        write_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic        err_q;
   logic        acc_err;
   logic [AW-1:0] word_idx;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [31:0] ram_rdata;

   assign acc_err  = addr_err(addr_q, ADDR_BASE, 32'(DEPTH_WORDS));
   assign word_idx = AW'((addr_q - ADDR_BASE) >> 2);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'hF;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  write_q <= req_write;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
`ifdef DMEM_BYTE_LANES_EN
                  be_q    <= req_be;
`else
                  be_q    <= 4'hF;
`endif
                  cnt_q   <= WS_LOAD;
               end
            end
            ST_WAIT:   if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            ST_ACCESS: err_q <= acc_err;
            ST_RESP:   if (rsp_ready) err_q <= 1'b0;
            default:   ;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 4'b0000;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            if (!acc_err) begin
               ram_en = 1'b1;
               ram_we = write_q ? be_q : 4'b0000;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // RAM output register holds the load result for the whole RESP phase.
   assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? ram_rdata : 32'd0;
   assign rsp_err   = err_q;

   dmem_array_32 #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (word_idx),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_dmem_responder_32.sv
// Self-checking bench for dmem_responder_32: directed scenarios plus randomized traffic vs. a word-array model.
module tb_dmem_responder_32;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned WS    = 2;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
`ifdef DMEM_BYTE_LANES_EN
   logic [3:0]  req_be = 4'hF;
`endif
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] model [int];

   always #5 clk = ~clk;

   dmem_responder_32 #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_STATES (WS),
      .ADDR_BASE   (BASE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
`ifdef DMEM_BYTE_LANES_EN
      .req_be    (req_be),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   function automatic logic exp_err(input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(BASE);
      return (a % 4 != 0) || (off < 0) || (off / 4 >= longint'(DEPTH));
   endfunction

   function automatic logic [3:0] lane_mask(input logic [3:0] be);
`ifdef DMEM_BYTE_LANES_EN
      return be;
`else
      return be | 4'hF;
`endif
   endfunction

   // One full transaction; response held for 'hold' extra cycles with rsp_ready low.
   task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output logic stable, output logic ready_after);
      int guard;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
`ifdef DMEM_BYTE_LANES_EN
      req_be    = be;
`endif
      req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata  = rsp_rdata;
      err    = rsp_err;
      stable = 1'b1;
      repeat (hold) begin
         @(posedge clk); #1;
         if (rsp_rdata !== rdata || rsp_err !== err || rsp_valid !== 1'b1 || req_ready !== 1'b0)
            stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      ready_after = req_ready && !rsp_valid;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h10;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      req_valid = 1'b0;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0})
         $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h, want rdy=1 vld=0 err=0 rdata=0",
                  req_ready, rsp_valid, rsp_err, rsp_rdata);
      else n_pass++;
      repeat (6) @(posedge clk);
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL reset_no_capture: got vld=%b rdy=%b, want vld=0 rdy=1", rsp_valid, req_ready);
      else n_pass++;
   endtask

   task automatic test_store_load();
      logic [31:0] rd; logic er, st, ra; int lat;
      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st, ra);
      n_checks++;
      if ({lat, er, rd} !== {WS + 2, 1'b0, 32'd0})
         $display("FAIL store_ack: got lat=%0d err=%b rdata=%h, want lat=%0d err=0 rdata=0", lat, er, rd, WS + 2);
      else n_pass++;
      n_checks++;
      if (ra !== 1'b1) $display("FAIL ready_after_rsp: got %b, want 1", ra);
      else n_pass++;
      txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, st, ra);
      n_checks++;
      if ({lat, er, rd} !== {WS + 2, 1'b0, 32'hDEADBEEF})
         $display("FAIL load_after_store: got lat=%0d err=%b rdata=%h, want lat=%0d err=0 rdata=deadbeef",
                  lat, er, rd, WS + 2);
      else n_pass++;
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er, st, ra; int lat;
      txn(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, rd, er, lat, st, ra);
      txn(1'b0, 32'h12, 32'h0, 4'hF, 0, rd, er, lat, st, ra);
      n_checks++;
      if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL misaligned_load: got err=%b rdata=%h, want err=1 rdata=0", er, rd);
      else n_pass++;
      txn(1'b0, 32'h400, 32'h0, 4'hF, 0, rd, er, lat, st, ra);
      n_checks++;
      if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL range_load: got err=%b rdata=%h, want err=1 rdata=0", er, rd);
      else n_pass++;
      txn(1'b1, 32'h12, 32'h55555555, 4'hF, 0, rd, er, lat, st, ra);
      txn(1'b1, 32'h400, 32'h66666666, 4'hF, 0, rd, er, lat, st, ra);
      n_checks++;
      if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL range_store: got err=%b rdata=%h, want err=1 rdata=0", er, rd);
      else n_pass++;
      txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, st, ra);
      n_checks++;
      if ({er, rd} !== {1'b0, 32'hDEADBEEF}) $display("FAIL word10_intact: got err=%b rdata=%h, want err=0 rdata=deadbeef", er, rd);
      else n_pass++;
      txn(1'b0, 32'h0, 32'h0, 4'hF, 0, rd, er, lat, st, ra);
      n_checks++;
      if ({er, rd} !== {1'b0, 32'h0BADF00D}) $display("FAIL no_alias_word0: got err=%b rdata=%h, want err=0 rdata=0badf00d", er, rd);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic er, st, ra; int guard, lat;
      req_write = 1'b0;
      req_addr  = 32'h10;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_write = 1'b1;
      req_wdata = 32'hBADBAD00;
      guard = 0;
      while (!rsp_valid && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      for (int c = 0; c < 10; c++) begin
         n_checks++;
         if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'hDEADBEEF})
            $display("FAIL hold_resp c%0d: got vld=%b rdy=%b err=%b rdata=%h, want vld=1 rdy=0 err=0 rdata=deadbeef",
                     c, rsp_valid, req_ready, rsp_err, rsp_rdata);
         else n_pass++;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL no_second_accept: got vld=%b, want 0", rsp_valid);
      else n_pass++;
      txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, st, ra);
      n_checks++;
      if (rd !== 32'hDEADBEEF) $display("FAIL ignored_req_no_write: got rdata=%h, want deadbeef", rd);
      else n_pass++;
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] rd; logic er, st, ra; int lat;
      txn(1'b1, 32'h20, 32'hCAFE0020, 4'hF, 0, rd, er, lat, st, ra);
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h12345678;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0})
         $display("FAIL wait_reset_outputs: got rdy=%b vld=%b err=%b rdata=%h, want rdy=1 vld=0 err=0 rdata=0",
                  req_ready, rsp_valid, rsp_err, rsp_rdata);
      else n_pass++;
      repeat (6) @(posedge clk);
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL wait_reset_dropped: got vld=%b, want 0", rsp_valid);
      else n_pass++;
      txn(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat, st, ra);
      n_checks++;
      if (rd !== 32'hCAFE0020) $display("FAIL wait_reset_no_commit: got rdata=%h, want cafe0020", rd);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int acc [2];
      int rv [2];
      logic [31:0] r [2];
      logic e [2];
      int k, j;
      logic [31:0] pat;
      pat = $urandom;
      acc = '{-100, -100}; rv = '{-100, -100};
      r = '{32'hFFFF_FFFF, 32'hFFFF_FFFF}; e = '{1'b1, 1'b1};
      k = 0; j = 0;
      req_write = 1'b1; req_addr = 32'h30; req_wdata = pat;
`ifdef DMEM_BYTE_LANES_EN
      req_be = 4'hF;
`endif
      req_valid = 1'b1; rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && j < 2; cyc++) begin
         if (req_valid && req_ready && k < 2) begin acc[k] = cyc; k++; end
         if (rsp_valid) begin r[j] = rsp_rdata; e[j] = rsp_err; rv[j] = cyc; j++; end
         @(posedge clk); #1;
         if (k == 1) begin req_write = 1'b0; req_wdata = 32'd0; end
         if (k == 2) req_valid = 1'b0;
      end
      req_valid = 1'b0; rsp_ready = 1'b0;
      n_checks++;
      if (acc[1] - acc[0] != int'(WS + 3))
         $display("FAIL accept_spacing: got %0d, want %0d", acc[1] - acc[0], WS + 3);
      else n_pass++;
      n_checks++;
      if (rv[0] - acc[0] != int'(WS + 2))
         $display("FAIL b2b_latency: got %0d, want %0d", rv[0] - acc[0], WS + 2);
      else n_pass++;
      n_checks++;
      if ({e[0], r[0], e[1], r[1]} !== {1'b0, 32'd0, 1'b0, pat})
         $display("FAIL b2b_store_then_load: got st=%b/%h ld=%b/%h, want 0/0 0/%h", e[0], r[0], e[1], r[1], pat);
      else n_pass++;
   endtask

`ifdef DMEM_BYTE_LANES_EN
   task automatic test_byte_lanes();
      logic [31:0] rd; logic er, st, ra; int lat;
      txn(1'b1, 32'h40, 32'hAABBCCDD, 4'hF, 0, rd, er, lat, st, ra);
      txn(1'b1, 32'h40, 32'h11223344, 4'b0101, 0, rd, er, lat, st, ra);
      txn(1'b0, 32'h40, 32'h0, 4'b0000, 0, rd, er, lat, st, ra);
      n_checks++;
      if (rd !== 32'hAA22CC44) $display("FAIL be_partial: got %h, want aa22cc44", rd);
      else n_pass++;
      txn(1'b1, 32'h40, 32'h99999999, 4'b0000, 0, rd, er, lat, st, ra);
      n_checks++;
      if ({er, rd, lat} !== {1'b0, 32'd0, WS + 2}) $display("FAIL be_zero_ack: got err=%b rdata=%h lat=%0d, want 0 0 %0d", er, rd, lat, WS + 2);
      else n_pass++;
      txn(1'b0, 32'h40, 32'h0, 4'b0000, 0, rd, er, lat, st, ra);
      n_checks++;
      if (rd !== 32'hAA22CC44) $display("FAIL be_zero_noop: got %h, want aa22cc44", rd);
      else n_pass++;
   endtask
`endif

   task automatic test_random();
      logic [31:0] rd, a, d, exp_rd, m; logic er, st, ra, wr, x_err; int lat, idx, hold, kind;
      logic [3:0] be, msk;
      for (int i = 0; i < 17; i++) begin
         idx = (i == 16) ? int'(DEPTH - 1) : 64 + i;
         d = $urandom;
         txn(1'b1, BASE + 32'(idx * 4), d, 4'hF, 0, rd, er, lat, st, ra);
         model[idx] = d;
         n_checks++;
         if ({er, rd} !== {1'b0, 32'd0}) $display("FAIL preload %0d: got err=%b rdata=%h, want 0 0", idx, er, rd);
         else n_pass++;
      end
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 3);
         idx  = ($urandom_range(0, 4) == 0) ? int'(DEPTH - 1) : 64 + $urandom_range(0, 15);
         wr   = (kind == 0) || (kind == 3 && $urandom_range(0, 1) == 1);
         a    = BASE + 32'(idx * 4);
         if (kind == 3) begin
            if ($urandom_range(0, 1) == 1) a = a + 32'($urandom_range(1, 3));
            else a = BASE + 32'((DEPTH + $urandom_range(0, 1000)) * 4);
         end
         d    = $urandom;
         be   = 4'($urandom);
         hold = $urandom_range(0, 3);
         x_err  = exp_err(a);
         exp_rd = 32'd0;
         if (!x_err) begin
            if (wr) begin
               msk = lane_mask(be);
               m = model[idx];
               for (int b = 0; b < 4; b++) if (msk[b]) m[b*8 +: 8] = d[b*8 +: 8];
               model[idx] = m;
            end else begin
               exp_rd = model[idx];
            end
         end
         txn(wr, a, d, be, hold, rd, er, lat, st, ra);
         n_checks++;
         if ({er, rd, lat} !== {x_err, exp_rd, WS + 2})
            $display("FAIL rand%0d %s a=%h: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                     t, wr ? "st" : "ld", a, er, rd, lat, x_err, exp_rd, WS + 2);
         else n_pass++;
         n_checks++;
         if ({st, ra} !== 2'b11) $display("FAIL rand%0d_hold: got stable=%b ready_after=%b, want 1 1", t, st, ra);
         else n_pass++;
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_errors();
      test_backpressure();
      test_reset_in_wait();
      test_back_to_back();
`ifdef DMEM_BYTE_LANES_EN
      test_byte_lanes();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder_32.md
# dmem_responder_32

Memory-side responder for the 32-bit MIPS core's load/store traffic. Accepts one word request at a time from the processor's data-access port over a valid/ready handshake, inserts a configurable number of wait states, then returns read data or a write acknowledgement with an error flag. Sits between the core datapath and the on-chip data RAM, replacing the zero-latency memory model.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the array; power of two, 16..4096
- WAIT_STATES, 2: cycles between request accept and array access; 0..15
- ADDR_BASE, 32'h0000_0000: byte address of word 0; word-aligned

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_write  in  1  1 = store (MemWrite), 0 = load (MemRead)
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables; present only with DMEM_BYTE_LANES_EN
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  misaligned or out-of-range address

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture write/addr/wdata(/be). Go to WAIT if WAIT_STATES>0 (load counter with WAIT_STATES-1), else ACCESS.
- WAIT: counter decrements each cycle; at 0 go to ACCESS.
- ACCESS: one cycle. Error check: addr[1:0]!=0, addr<ADDR_BASE, or (addr-ADDR_BASE)>>2 >= DEPTH_WORDS → no array access, rsp_err=1, rsp_rdata=0. Otherwise store commits to array, or load reads array (word index = (addr-ADDR_BASE)>>2, truncated to log2(DEPTH_WORDS) bits after range check). Go to RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready, then IDLE.
- Request inputs ignored outside IDLE; captured values, not live inputs, used for access.
- Array contents not reset; load of unwritten word returns X in sim.

## Timing
- Reset values: state IDLE, req_ready=1 (first cycle after reset deasserts), rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Accept in cycle N → rsp_valid first high in cycle N+WAIT_STATES+2.
- Response handshake in cycle M → req_ready high in cycle M+1; minimum spacing between accepts = WAIT_STATES+3 cycles.
- Store committed at ACCESS edge; a load accepted afterwards returns new data.
- Reset during WAIT: transaction dropped, no write committed. Reset during ACCESS/RESP: write already committed stays; response discarded.
- rsp_ready held low: RESP holds indefinitely, req_ready stays 0.
- req_valid and reset in same cycle: reset wins, nothing captured.

## Configuration
- DMEM_BYTE_LANES_EN defined: req_be port exists; store writes only lanes with req_be[i]=1 (lane 0 = bits 7:0); req_be=0 is a legal no-op store with normal ack. Loads ignore req_be and return the full word.
- Undefined: no req_be port; every store writes all 4 bytes.
- Alignment/range check identical in both builds.

## Structure
- Package dmem_pkg: FSM state enum, WORD_BYTES=4, lane-width constant, error-check function.
- Sub-module dmem_array_32: single-port synchronous RAM, DEPTH_WORDS×32, 4-bit byte write enable (tied 4'hF when macro undefined), registered read.

## Test plan
- Reset, then store 0xDEADBEEF to 0x0000_0010 (WAIT_STATES=2): accept at N, rsp_valid at N+4, rsp_err=0, rsp_rdata=0.
- Load 0x0000_0010 right after → rsp_rdata=0xDEADBEEF, rsp_err=0.
- Load 0x0000_0012 (misaligned) and 0x0000_0400 (DEPTH 256 → out of range) → rsp_err=1, rsp_rdata=0; word 0x10 unchanged.
- Hold rsp_ready=0 for 10 cycles in RESP with req_valid=1 → rsp_valid and data stable, req_ready=0, no second accept.
- Assert reset in WAIT of a store 0x12345678 to 0x20 → later load of 0x20 returns prior value; outputs at reset values.
- With DMEM_BYTE_LANES_EN: store 0xAABBCCDD, then store 0x11223344 be=4'b0101 to same word → load returns 0xAA22CC44.
